// File: rtl/alu_op_decoder.sv
// RV32I decode stage feeding the ALU, with a 2-entry skid buffer on the output side.
// Define ALUDEC_ILLEGAL_EN to flag unsupported encodings on the illegal output.
module alu_op_decoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_op,
    output logic [1:0]  a_sel,
    output logic        b_is_imm,
    output logic [31:0] imm,
    output logic        is_branch,
    output logic        br_inv,
    output logic        illegal
);
`ifdef ALUDEC_ILLEGAL_EN
    localparam logic ILLEGAL_EN = 1'b1;
`else
    localparam logic ILLEGAL_EN = 1'b0;
`endif

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_TWO   = 2'd2;

    localparam int W = 42;

    logic [6:0]  w_opcode;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh;

    assign w_opcode = in_instr[6:0];
    assign w_f3     = in_instr[14:12];
    assign w_f7     = in_instr[31:25];
    assign w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_imm_u  = {in_instr[31:12], 12'b0};
    assign w_imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign w_imm_sh = {27'b0, in_instr[24:20]};

    // alt selects sub (funct3 000) or sra (funct3 101); callers gate it per opcode.
    function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  f3_op = alt ? OP_SUB : OP_ADD;
            3'b001:  f3_op = OP_SLL;
            3'b010:  f3_op = OP_SLT;
            3'b011:  f3_op = OP_SLTU;
            3'b100:  f3_op = OP_XOR;
            3'b101:  f3_op = alt ? OP_SRA : OP_SRL;
            3'b110:  f3_op = OP_OR;
            default: f3_op = OP_AND;
        endcase
    endfunction

    logic [3:0]  w_alu_op;
    logic [1:0]  w_a_sel;
    logic        w_b_is_imm, w_is_branch, w_br_inv;
    logic [31:0] w_imm;
    logic        w_unsup, w_strict, w_kill;
    logic [W-1:0] w_word;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        w_alu_op    = OP_ADD;
        w_a_sel     = 2'b00;
        w_b_is_imm  = 1'b0;
        w_imm       = '0;
        w_is_branch = 1'b0;
        w_br_inv    = 1'b0;
        w_unsup     = 1'b0;
        w_strict    = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_alu_op = f3_op(w_f3, w_f7[5] && (w_f3 == 3'b000 || w_f3 == 3'b101));
                w_strict = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
            end
            OPC_OPIMM: begin
                w_alu_op   = f3_op(w_f3, w_f7[5] && (w_f3 == 3'b101));
                w_b_is_imm = 1'b1;
                if (w_f3 == 3'b001) begin
                    w_imm    = w_imm_sh;
                    w_strict = (w_f7 != 7'b0000000);
                end else if (w_f3 == 3'b101) begin
                    w_imm    = w_imm_sh;
                    w_strict = (w_f7 != 7'b0000000) && (w_f7 != 7'b0100000);
                end else begin
                    w_imm = w_imm_i;
                end
            end
            OPC_LOAD:  begin w_b_is_imm = 1'b1; w_imm = w_imm_i; end
            OPC_STORE: begin w_b_is_imm = 1'b1; w_imm = w_imm_s; end
            OPC_BRANCH: begin
                w_is_branch = 1'b1;
                w_imm       = w_imm_b;
                w_br_inv    = w_f3[0];
                case (w_f3[2:1])
                    2'b00:   w_alu_op = OP_SUB;
                    2'b10:   w_alu_op = OP_SLT;
                    2'b11:   w_alu_op = OP_SLTU;
                    default: w_unsup  = 1'b1;
                endcase
            end
            OPC_LUI:   begin w_a_sel = 2'b10; w_b_is_imm = 1'b1; w_imm = w_imm_u; end
            OPC_AUIPC: begin w_a_sel = 2'b01; w_b_is_imm = 1'b1; w_imm = w_imm_u; end
            OPC_JAL:   begin w_a_sel = 2'b01; w_b_is_imm = 1'b1; w_imm = w_imm_j; end
            OPC_JALR:  begin w_b_is_imm = 1'b1; w_imm = w_imm_i; end
            default:   w_unsup = 1'b1;
        endcase
    end

    assign w_kill = w_unsup | (ILLEGAL_EN & w_strict);
    assign w_word = w_kill ? {{(W-1){1'b0}}, ILLEGAL_EN}
                           : {w_alu_op, w_a_sel, w_b_is_imm, w_imm, w_is_branch, w_br_inv, 1'b0};

    logic [1:0]   r_state;
    logic [W-1:0] r_head, r_tail;
    logic         w_accept, w_pop;

    assign in_ready  = ~rst & (r_state != S_TWO);
    assign out_valid = (r_state != S_EMPTY);
    assign w_accept  = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    // NOTE: both entries are cleared on reset so the outputs read zero while empty after reset.
    // NOTE: sequential state uses non-blocking assignments so r_head <= r_tail sees the old tail.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case (r_state)
                S_EMPTY: if (w_accept) begin
                    r_head  <= w_word;
                    r_state <= S_ONE;
                end
                S_ONE: begin
                    if (w_accept && w_pop) begin
                        r_head <= w_word;
                    end else if (w_accept) begin
                        r_tail  <= w_word;
                        r_state <= S_TWO;
                    end else if (w_pop) begin
                        r_state <= S_EMPTY;
                    end
                end
                S_TWO: if (w_pop) begin
                    r_head  <= r_tail;
                    r_state <= S_ONE;
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    assign {alu_op, a_sel, b_is_imm, imm, is_branch, br_inv, illegal} = r_head;
endmodule
